// File: rtl/lynx_tap_player.sv
// Captures a TAP image from the ioctl download stream and replays it as a square-wave ear signal.
// Playback starts one clock after play is sampled and never stalls; stop or a new download aborts it.
module lynx_tap_player #(
  parameter int          AW        = 16,
  parameter logic [7:0]  TAP_INDEX = 8'd1,
  parameter int          HALF0     = 2400,
  parameter int          HALF1     = 4800,
  parameter int          LEADER    = 768,
  parameter bit          AUTOPLAY  = 1'b0
) (
  input  logic          clk_sys,
  input  logic          reset,
  input  logic          ioctl_download,
  input  logic [7:0]    ioctl_index,
  input  logic          ioctl_wr,
  input  logic [24:0]   ioctl_addr,
  input  logic [7:0]    ioctl_data,
  input  logic          play,
  input  logic          stop,
  output logic          ear,
  output logic          playing,
  output logic          loaded,
  output logic          done,
  output logic          overflow,
  output logic [AW:0]   tape_len
);

  localparam int HMAX = (HALF1 > HALF0) ? HALF1 : HALF0;
  localparam int HW   = $clog2(HMAX + 1);
  localparam int LW   = $clog2(LEADER + 1);
  localparam logic [HW-1:0] H0M1 = HW'(HALF0 - 1);
  localparam logic [HW-1:0] H1M1 = HW'(HALF1 - 1);

  typedef enum logic [1:0] {S_IDLE, S_LEADER, S_SYNC, S_DATA} state_t;

  logic [7:0]    mem [0:(2**AW)-1];
  logic [7:0]    rd_dat_q;

  state_t        state_q;
  logic [HW-1:0] cnt_q;
  logic          low_q;
  logic          bit_q;
  logic [LW-1:0] lead_q;
  logic [7:0]    shreg_q;
  logic [2:0]    bitn_q;
  logic [AW:0]   ptr_q;
  logic          dl_q;
  logic          ear_q, playing_q, loaded_q, done_q, ovf_q;
  logic [AW:0]   len_q;

  logic          dl_act, dl_start, dl_end, in_range, wr_ok, start_go, ovf_d;
  logic [AW:0]   addr_p1, len_base, len_d;

  always_comb begin
    dl_act   = ioctl_download && (ioctl_index == TAP_INDEX);
    dl_start = dl_act && !dl_q;
    dl_end   = !dl_act && dl_q;
    in_range = ((ioctl_addr >> AW) == 25'd0);
    wr_ok    = dl_act && ioctl_wr && in_range;
    addr_p1  = {1'b0, ioctl_addr[AW-1:0]} + (AW+1)'(1);
    len_base = dl_start ? '0 : len_q;
    len_d    = (wr_ok && (addr_p1 > len_base)) ? addr_p1 : len_base;
    ovf_d    = (dl_start ? 1'b0 : ovf_q) | (dl_act && ioctl_wr && !in_range);
    // Autoplay uses the final length directly since loaded only rises on this same edge
    start_go = (play && !stop && loaded_q && !dl_act) ||
               (AUTOPLAY && dl_end && (len_q != '0));
  end

  always_ff @(posedge clk_sys) begin
    if (wr_ok) mem[ioctl_addr[AW-1:0]] <= ioctl_data;
    rd_dat_q <= mem[ptr_q[AW-1:0]];
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      low_q     <= 1'b0;
      bit_q     <= 1'b0;
      lead_q    <= '0;
      shreg_q   <= '0;
      bitn_q    <= '0;
      ptr_q     <= '0;
      dl_q      <= 1'b0;
      ear_q     <= 1'b0;
      playing_q <= 1'b0;
      loaded_q  <= 1'b0;
      done_q    <= 1'b0;
      ovf_q     <= 1'b0;
      len_q     <= '0;
    end else begin
      dl_q   <= dl_act;
      len_q  <= len_d;
      ovf_q  <= ovf_d;
      done_q <= 1'b0;
      if (dl_start)    loaded_q <= 1'b0;
      else if (dl_end) loaded_q <= (len_q != '0);

      if (dl_start || (stop && state_q != S_IDLE)) begin
        state_q   <= S_IDLE;
        ear_q     <= 1'b0;
        playing_q <= 1'b0;
        ptr_q     <= '0;
      end else if (state_q == S_IDLE) begin
        if (start_go) begin
          state_q   <= S_LEADER;
          playing_q <= 1'b1;
          ear_q     <= 1'b1;
          ptr_q     <= '0;
          lead_q    <= LW'(LEADER - 1);
          bit_q     <= 1'b0;
          low_q     <= 1'b0;
          cnt_q     <= H0M1;
        end
      end else if (cnt_q != '0) begin
        cnt_q <= cnt_q - HW'(1);
      end else if (!low_q) begin
        low_q <= 1'b1;
        ear_q <= 1'b0;
        cnt_q <= bit_q ? H1M1 : H0M1;
      end else begin
        // End of a full bit cycle: launch the next bit with no idle clock
        low_q <= 1'b0;
        ear_q <= 1'b1;
        case (state_q)
          S_LEADER: begin
            if (lead_q != '0) begin
              lead_q <= lead_q - LW'(1);
              bit_q  <= 1'b0;
              cnt_q  <= H0M1;
            end else begin
              state_q <= S_SYNC;
              bit_q   <= 1'b1;
              cnt_q   <= H1M1;
            end
          end
          S_SYNC: begin
            state_q <= S_DATA;
            shreg_q <= rd_dat_q;
            bitn_q  <= 3'd7;
            ptr_q   <= ptr_q + (AW+1)'(1);
            bit_q   <= rd_dat_q[7];
            cnt_q   <= rd_dat_q[7] ? H1M1 : H0M1;
          end
          S_DATA: begin
            if (bitn_q != 3'd0) begin
              shreg_q <= {shreg_q[6:0], 1'b0};
              bitn_q  <= bitn_q - 3'd1;
              bit_q   <= shreg_q[6];
              cnt_q   <= shreg_q[6] ? H1M1 : H0M1;
            end else if (ptr_q < len_q) begin
              shreg_q <= rd_dat_q;
              bitn_q  <= 3'd7;
              ptr_q   <= ptr_q + (AW+1)'(1);
              bit_q   <= rd_dat_q[7];
              cnt_q   <= rd_dat_q[7] ? H1M1 : H0M1;
            end else begin
              state_q   <= S_IDLE;
              ear_q     <= 1'b0;
              playing_q <= 1'b0;
              done_q    <= 1'b1;
              ptr_q     <= '0;
            end
          end
          default: begin
            state_q   <= S_IDLE;
            ear_q     <= 1'b0;
            playing_q <= 1'b0;
          end
        endcase
      end
    end
  end

  assign ear      = ear_q;
  assign playing  = playing_q;
  assign loaded   = loaded_q;
  assign done     = done_q;
  assign overflow = ovf_q;
  assign tape_len = len_q;

endmodule

// File: tb/tb_lynx_tap_player.sv
// Directed bench for lynx_tap_player with short bit timings and a 16-byte buffer.
// A second instance with autoplay enabled shares the stimulus.
module tb_lynx_tap_player;

  localparam int AW = 4;
  localparam int H0 = 4;
  localparam int H1 = 8;

  logic          clk_sys = 1'b0;
  logic          reset, ioctl_download, ioctl_wr, play, stop;
  logic [7:0]    ioctl_index, ioctl_data;
  logic [24:0]   ioctl_addr;
  logic          ear, playing, loaded, done, overflow;
  logic [AW:0]   tape_len;
  logic          ap_ear, ap_playing, ap_loaded, ap_done, ap_overflow;
  logic [AW:0]   ap_tape_len;

  int n_chk  = 0;
  int n_fail = 0;

  logic [7:0] img[$];
  int         wave[$];
  logic       seen;

  always #5 clk_sys = ~clk_sys;

  lynx_tap_player #(.AW(AW), .TAP_INDEX(8'd1), .HALF0(H0), .HALF1(H1), .LEADER(4), .AUTOPLAY(1'b0)) dut (
    .clk_sys(clk_sys), .reset(reset), .ioctl_download(ioctl_download), .ioctl_index(ioctl_index),
    .ioctl_wr(ioctl_wr), .ioctl_addr(ioctl_addr), .ioctl_data(ioctl_data), .play(play), .stop(stop),
    .ear(ear), .playing(playing), .loaded(loaded), .done(done), .overflow(overflow), .tape_len(tape_len)
  );

  lynx_tap_player #(.AW(AW), .TAP_INDEX(8'd1), .HALF0(H0), .HALF1(H1), .LEADER(4), .AUTOPLAY(1'b1)) dut_ap (
    .clk_sys(clk_sys), .reset(reset), .ioctl_download(ioctl_download), .ioctl_index(ioctl_index),
    .ioctl_wr(ioctl_wr), .ioctl_addr(ioctl_addr), .ioctl_data(ioctl_data), .play(play), .stop(stop),
    .ear(ap_ear), .playing(ap_playing), .loaded(ap_loaded), .done(ap_done), .overflow(ap_overflow),
    .tape_len(ap_tape_len)
  );

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic push_bit(input bit b);
    int h;
    h = b ? H1 : H0;
    repeat (h) wave.push_back(1);
    repeat (h) wave.push_back(0);
  endtask

  task automatic dl_begin(input logic [7:0] idx);
    @(negedge clk_sys);
    ioctl_download = 1'b1;
    ioctl_index    = idx;
  endtask

  task automatic dl_write(input logic [24:0] addr, input logic [7:0] data);
    @(negedge clk_sys);
    ioctl_wr   = 1'b1;
    ioctl_addr = addr;
    ioctl_data = data;
    @(negedge clk_sys);
    ioctl_wr   = 1'b0;
  endtask

  task automatic dl_end();
    @(negedge clk_sys);
    ioctl_download = 1'b0;
    @(negedge clk_sys);
  endtask

  task automatic pulse_play();
    @(negedge clk_sys);
    play = 1'b1;
    @(negedge clk_sys);
    play = 1'b0;
  endtask

  // Full playback of img, sample 0 taken the cycle after play is sampled
  task automatic play_check();
    wave.delete();
    for (int i = 0; i < 4; i++) push_bit(1'b0);
    push_bit(1'b1);
    foreach (img[j])
      for (int b = 7; b >= 0; b--) push_bit(img[j][b]);
    pulse_play();
    foreach (wave[i]) begin
      check("ear_wave", ear, wave[i]);
      check("playing_during", playing, 1);
      @(negedge clk_sys);
    end
    check("done_pulse", done, 1);
    check("playing_end", playing, 0);
    check("ear_end", ear, 0);
    @(negedge clk_sys);
    check("done_one_cycle", done, 0);
  endtask

  initial begin
    reset = 1'b1; ioctl_download = 1'b0; ioctl_wr = 1'b0; play = 1'b0; stop = 1'b0;
    ioctl_index = 8'd0; ioctl_addr = '0; ioctl_data = '0;
    repeat (3) @(negedge clk_sys);
    check("rst_ear", ear, 0);
    check("rst_playing", playing, 0);
    check("rst_loaded", loaded, 0);
    check("rst_done", done, 0);
    check("rst_overflow", overflow, 0);
    check("rst_tape_len", tape_len, 0);
    reset = 1'b0;

    // Three-byte image, then full playback across byte boundaries
    dl_begin(8'd1);
    dl_write(25'd0, 8'hA5);
    dl_write(25'd1, 8'h00);
    dl_write(25'd2, 8'hFF);
    dl_end();
    check("s1_tape_len", tape_len, 3);
    check("s1_loaded", loaded, 1);
    check("s1_overflow", overflow, 0);
    check("s1_playing", playing, 0);
    img = {8'hA5, 8'h00, 8'hFF};
    play_check();

    // Single byte A5
    dl_begin(8'd1);
    dl_write(25'd0, 8'hA5);
    dl_end();
    check("s2_tape_len", tape_len, 1);
    img = {8'hA5};
    play_check();

    // Stop on the third data bit, then restart with a full leader
    pulse_play();
    repeat (72) @(negedge clk_sys);
    check("s3_ear_bit2", ear, 1);
    stop = 1'b1;
    @(negedge clk_sys);
    stop = 1'b0;
    check("s3_ear_stop", ear, 0);
    check("s3_playing_stop", playing, 0);
    seen = 1'b0;
    repeat (20) begin
      seen = seen | done;
      @(negedge clk_sys);
    end
    check("s3_no_done", seen, 0);
    play_check();

    // Foreign index ignored; then overflow with an empty image
    dl_begin(8'd2);
    dl_write(25'd0, 8'h00);
    dl_write(25'd3, 8'h11);
    dl_end();
    check("s4_len_idx2", tape_len, 1);
    check("s4_loaded_idx2", loaded, 1);
    play_check();
    dl_begin(8'd1);
    @(negedge clk_sys);
    check("s4_loaded_clr", loaded, 0);
    dl_write(25'd16, 8'h77);
    dl_end();
    check("s4_overflow", overflow, 1);
    check("s4_tape_len", tape_len, 0);
    check("s4_loaded", loaded, 0);
    pulse_play();
    @(negedge clk_sys);
    check("s4_play_ignored", playing, 0);

    // New download aborts playback; autoplay instance restarts after it
    dl_begin(8'd1);
    dl_write(25'd0, 8'hA5);
    dl_end();
    pulse_play();
    repeat (10) @(negedge clk_sys);
    check("s5_playing", playing, 1);
    dl_begin(8'd1);
    @(negedge clk_sys);
    check("s5_abort_playing", playing, 0);
    check("s5_abort_ear", ear, 0);
    check("s5_abort_len", tape_len, 0);
    check("s5_ap_abort", ap_playing, 0);
    dl_write(25'd0, 8'h3C);
    @(negedge clk_sys);
    check("s5_ap_wait", ap_playing, 0);
    ioctl_download = 1'b0;
    @(negedge clk_sys);
    check("s5_ap_playing", ap_playing, 1);
    check("s5_ap_ear", ap_ear, 1);
    check("s5_ap_loaded", ap_loaded, 1);
    check("s5_no_autoplay", playing, 0);
    repeat (144) @(negedge clk_sys);
    check("s5_ap_done", ap_done, 1);
    check("s5_ap_playing_end", ap_playing, 0);

    // Reset mid-DATA
    dl_begin(8'd1);
    dl_write(25'd0, 8'hA5);
    dl_write(25'd20, 8'h00);
    dl_end();
    check("s6_overflow", overflow, 1);
    check("s6_tape_len", tape_len, 1);
    pulse_play();
    repeat (60) @(negedge clk_sys);
    reset = 1'b1;
    @(negedge clk_sys);
    reset = 1'b0;
    check("s6_ear", ear, 0);
    check("s6_playing", playing, 0);
    check("s6_loaded", loaded, 0);
    check("s6_done", done, 0);
    check("s6_overflow_rst", overflow, 0);
    check("s6_tape_len_rst", tape_len, 0);
    pulse_play();
    seen = 1'b0;
    repeat (5) begin
      seen = seen | playing;
      @(negedge clk_sys);
    end
    check("s6_play_ignored", seen, 0);
    dl_begin(8'd1);
    dl_write(25'd0, 8'hA5);
    dl_end();
    play_check();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
